// File: rtl/fp_pkg.sv
// Single-precision field widths and operand class codes shared by the unpack
// and special-case stages. Pure declarations, no timing or flow control.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int FP_W   = 1 + EXP_W + MANT_W;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    FP_ZERO    = 3'b000,
    FP_INF     = 3'b001,
    FP_SUBNORM = 3'b010,
    FP_NORMAL  = 3'b011,
    FP_NAN     = 3'b100
  } fp_class_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    fp_class_e         cls;
  } fp_op_t;

  // Signaling NaN: all-ones exponent, non-zero mantissa, quiet bit clear.
  function automatic logic is_snan(input logic [EXP_W-1:0] exp, input logic [MANT_W-1:0] mant);
    return (exp == EXP_MAX) && (mant != '0) && !mant[MANT_W-1];
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic in-order FIFO; data visible at the head one cycle after a push into an empty queue.
// push_rdy comes from registered count only, so a same-cycle pop never frees space for a push.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          rdy_en;
  logic          push;
  logic          pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + AW'(1);
  endfunction

  // rdy_en keeps push_rdy low through reset and rises on the first edge after release.
  assign push_rdy = rdy_en && (count != FULL);
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fp_classify.sv
// Splits one single-precision word into fields and a class code.
// Purely combinational (zero latency); no flow control.
module fp_classify
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] op,
  output fp_op_t          unp,
  output logic            snan
);

  logic [EXP_W-1:0]  exp;
  logic [MANT_W-1:0] mant;

  assign exp  = op[FP_W-2 -: EXP_W];
  assign mant = op[MANT_W-1:0];

  always_comb begin
    unp.sign = op[FP_W-1];
    unp.exp  = exp;
    unp.mant = mant;
    unp.cls  = FP_NORMAL;
    if (exp == '0) begin
      unp.cls = (mant == '0) ? FP_ZERO : FP_SUBNORM;
    end else if (exp == EXP_MAX) begin
      unp.cls = (mant == '0) ? FP_INF : FP_NAN;
    end
  end

  assign snan = is_snan(exp, mant);

endmodule

// File: rtl/fp_unpack_stage.sv
// Classifies an operand pair and queues it in a 2-entry FIFO; latency 1 into an empty queue.
// in_ready is registered (low when two entries are held, even if the head pops that cycle).
module fp_unpack_stage
  import fp_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   in_a,
  input  logic [FP_W-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign_a,
  output logic              out_sign_b,
  output logic [EXP_W-1:0]  out_exp_a,
  output logic [EXP_W-1:0]  out_exp_b,
  output logic [MANT_W-1:0] out_mantis_a,
  output logic [MANT_W-1:0] out_mantis_b,
  output logic [2:0]        out_type_a,
  output logic [2:0]        out_type_b,
  output logic              out_snan,
  output logic [TAG_W-1:0]  out_tag
);

  typedef struct packed {
    fp_op_t             a;
    fp_op_t             b;
    logic               snan;
    logic [TAG_W-1:0]   tag;
  } entry_t;

  fp_op_t unp_a;
  fp_op_t unp_b;
  logic   snan_a;
  logic   snan_b;
  entry_t wr_dat;
  entry_t rd_dat;

  fp_classify u_cls_a (
    .op   (in_a),
    .unp  (unp_a),
    .snan (snan_a)
  );

  fp_classify u_cls_b (
    .op   (in_b),
    .unp  (unp_b),
    .snan (snan_b)
  );

  always_comb begin
    wr_dat      = '0;
    wr_dat.a    = unp_a;
    wr_dat.b    = unp_b;
    wr_dat.snan = snan_a || snan_b;
    wr_dat.tag  = in_tag;
  end

  fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (wr_dat),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (rd_dat)
  );

  assign out_sign_a   = rd_dat.a.sign;
  assign out_sign_b   = rd_dat.b.sign;
  assign out_exp_a    = rd_dat.a.exp;
  assign out_exp_b    = rd_dat.b.exp;
  assign out_mantis_a = rd_dat.a.mant;
  assign out_mantis_b = rd_dat.b.mant;
  assign out_type_a   = rd_dat.a.cls;
  assign out_type_b   = rd_dat.b.cls;
  assign out_snan     = rd_dat.snan;
  assign out_tag      = rd_dat.tag;

endmodule

// File: tb/tb_fp_unpack_stage.sv
// Directed bench for fp_unpack_stage: queue-based reference model checked every
// cycle, plus literal expectations for the named scenarios.
module tb_fp_unpack_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign_a;
  logic        out_sign_b;
  logic [7:0]  out_exp_a;
  logic [7:0]  out_exp_b;
  logic [22:0] out_mantis_a;
  logic [22:0] out_mantis_b;
  logic [2:0]  out_type_a;
  logic [2:0]  out_type_b;
  logic        out_snan;
  logic [3:0]  out_tag;

  fp_unpack_stage #(.TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign_a   (out_sign_a),
    .out_sign_b   (out_sign_b),
    .out_exp_a    (out_exp_a),
    .out_exp_b    (out_exp_b),
    .out_mantis_a (out_mantis_a),
    .out_mantis_b (out_mantis_b),
    .out_type_a   (out_type_a),
    .out_type_b   (out_type_b),
    .out_snan     (out_snan),
    .out_tag      (out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: classification straight from the IEEE-754 field rules.
  function automatic bit [2:0] cls_of(input bit [31:0] x);
    bit [7:0]  e = x[30:23];
    bit [22:0] m = x[22:0];
    if (e == 8'h00) return (m == 0) ? 3'b000 : 3'b010;
    if (e == 8'hFF) return (m == 0) ? 3'b001 : 3'b100;
    return 3'b011;
  endfunction

  function automatic bit snan_of(input bit [31:0] x);
    return (cls_of(x) == 3'b100) && !x[22];
  endfunction

  typedef struct {
    bit [31:0] a;
    bit [31:0] b;
    bit [3:0]  tag;
  } pair_t;

  pair_t q[$];
  bit    m_run = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        q.delete();
        m_run = 1'b0;
      end else begin
        bit    do_push;
        bit    do_pop;
        pair_t p;
        do_push = (in_valid === 1'b1) && m_run && (q.size() < 2);
        do_pop  = (q.size() > 0) && (out_ready === 1'b1);
        p.a   = in_a;
        p.b   = in_b;
        p.tag = in_tag;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(p);
        m_run = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("m_in_ready", in_ready, (m_run && q.size() < 2));
      check("m_out_valid", out_valid, (q.size() > 0));
      if (q.size() > 0) begin
        check("m_sign_a", out_sign_a, q[0].a[31]);
        check("m_sign_b", out_sign_b, q[0].b[31]);
        check("m_exp_a", out_exp_a, q[0].a[30:23]);
        check("m_exp_b", out_exp_b, q[0].b[30:23]);
        check("m_mant_a", out_mantis_a, q[0].a[22:0]);
        check("m_mant_b", out_mantis_b, q[0].b[22:0]);
        check("m_type_a", out_type_a, cls_of(q[0].a));
        check("m_type_b", out_type_b, cls_of(q[0].b));
        check("m_snan", out_snan, snan_of(q[0].a) || snan_of(q[0].b));
        check("m_tag", out_tag, q[0].tag);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
  endtask

  logic [31:0] vec_a [6] = '{32'h40490FDB, 32'h00800000, 32'hFF800000, 32'hFFBFFFFF, 32'h807FFFFF, 32'h7F7FFFFF};
  logic [31:0] vec_b [6] = '{32'hC0000000, 32'h807FFFFF, 32'h7F800000, 32'h3F800000, 32'h7FA00000, 32'h00000000};

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_exp_a", out_exp_a, 0);
    check("rst_mant_b", out_mantis_b, 0);
    check("rst_snan", out_snan, 0);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", in_ready, 0);
    tick();
    check("rdy_after_release", in_ready, 1);

    // 1.0 and -0.0
    out_ready = 1'b1;
    set_in(1'b1, 32'h3F800000, 32'h80000000, 4'd5);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    check("t1_valid", out_valid, 1);
    check("t1_type_a", out_type_a, 3'b011);
    check("t1_type_b", out_type_b, 3'b000);
    check("t1_sign_b", out_sign_b, 1);
    check("t1_tag", out_tag, 5);
    check("t1_snan", out_snan, 0);
    tick();
    check("t1_drained", out_valid, 0);

    // NaN flavours and infinity
    set_in(1'b1, 32'h7F800001, 32'h7FC00000, 4'd6);
    tick();
    set_in(1'b1, 32'h7FC00000, 32'hFF800000, 4'd7);
    check("t2_type_a", out_type_a, 3'b100);
    check("t2_type_b", out_type_b, 3'b100);
    check("t2_snan", out_snan, 1);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    check("t2b_type_a", out_type_a, 3'b100);
    check("t2b_type_b", out_type_b, 3'b001);
    check("t2b_snan", out_snan, 0);
    check("t2b_tag", out_tag, 7);
    tick();

    // smallest subnormal
    set_in(1'b1, 32'h00000001, 32'h00000000, 4'd8);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    check("t3_type_a", out_type_a, 3'b010);
    check("t3_exp_a", out_exp_a, 0);
    check("t3_mant_a", out_mantis_a, 23'h000001);
    tick();

    // mixed vectors with intermittent backpressure
    for (int i = 0; i < 6; i++) begin
      out_ready = i[0];
      set_in(1'b1, vec_a[i], vec_b[i], 4'(i + 10));
      tick();
    end
    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    out_ready = 1'b1;
    repeat (4) tick();

    // fill to two entries, third request must be ignored
    out_ready = 1'b0;
    set_in(1'b1, 32'h3F800000, 32'h40000000, 4'd1);
    tick();
    set_in(1'b1, 32'h40400000, 32'h40800000, 4'd2);
    tick();
    check("t4_full_rdy", in_ready, 0);
    check("t4_head1", out_tag, 1);
    set_in(1'b1, 32'h40A00000, 32'h40C00000, 4'd3);
    tick();
    check("t4_still_full", in_ready, 0);
    check("t4_head1_hold", out_tag, 1);
    out_ready = 1'b1;
    #1;
    check("t4_no_comb_rdy", in_ready, 0);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    check("t4_rdy_after_pop", in_ready, 1);
    check("t4_head2", out_tag, 2);
    tick();
    check("t4_empty", out_valid, 0);

    // steady state with one entry: push and pop every cycle
    out_ready = 1'b0;
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 4'd15);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 32'h3F800000 + 32'(i), 32'hBF800000 - 32'(i), 4'(i));
      tick();
      check("t5_tag", out_tag, i);
      check("t5_rdy", in_ready, 1);
      check("t5_valid", out_valid, 1);
    end
    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check("t5_drained", out_valid, 0);

    // asynchronous reset with two entries buffered
    out_ready = 1'b0;
    set_in(1'b1, 32'h41000000, 32'h41100000, 4'd9);
    tick();
    set_in(1'b1, 32'h41200000, 32'h41300000, 4'd10);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 4'h0);
    check("t6_full_valid", out_valid, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_rdy", in_ready, 0);
    check("t6_rst_tag", out_tag, 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      check("t6_no_ghost", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
